// File: rtl/fdivsqrt_pkg.sv
// Shared sizing and state type for the div/sqrt/int-div sequencer.
package fdivsqrt_pkg;

    localparam int CFG_DURLEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fdivsqrt_state_t;

endpackage

// File: rtl/fdivsqrt_stepctr.sv
// Loadable down-counter tracking remaining iteration cycles; flags the final step.
module fdivsqrt_stepctr
    import fdivsqrt_pkg::*;
#(
    parameter int W = CFG_DURLEN
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_loadVal,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Decrement stops at zero so the count can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_last = (r_count == W'(1));

endmodule

// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencer for the shared FP div/sqrt and integer div/rem iteration datapath.
module fdivsqrt_seq_ctrl
    import fdivsqrt_pkg::*;
#(
    parameter int DURLEN = CFG_DURLEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              FDivStartE,
    input  logic              IDivStartE,
    input  logic              SpecialCaseE,
    input  logic              ISpecialCaseE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              StallM,
    input  logic              FlushE,
    output logic              IFDivStartE,
    output logic              IterEnE,
    output logic              FDivBusyE,
    output logic              FDivDoneE,
    output logic              SpecialCaseM,
    output logic              IntDivOpM
);

    fdivsqrt_state_t r_state;
    fdivsqrt_state_t w_nextState;

    logic w_req;
    logic w_sp;
    logic w_quick;
    logic w_load;
    logic w_stepLast;

    // FP takes precedence if both starts are (illegally) raised together.
    assign w_req   = FDivStartE | IDivStartE;
    assign w_sp    = FDivStartE ? SpecialCaseE : ISpecialCaseE;
    assign w_quick = w_sp | (CyclesE == '0);
    assign w_load  = IFDivStartE & ~w_quick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (IFDivStartE) begin
                    w_nextState = w_quick ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (FlushE) begin
                    w_nextState = IDLE;
                end else if (w_stepLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (FlushE || !StallM) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Launch strobe is masked during reset so every output reads 0 while reset_n is low.
    always_comb begin
        IFDivStartE = reset_n & w_req & (r_state == IDLE) & ~FlushE;
        IterEnE     = (r_state == BUSY) & ~FlushE;
        FDivDoneE   = (r_state == DONE) & ~FlushE;
        FDivBusyE   = (r_state == BUSY) | ((r_state == DONE) & StallM) | IFDivStartE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            SpecialCaseM <= 1'b0;
            IntDivOpM    <= 1'b0;
        end else if (IFDivStartE) begin
            SpecialCaseM <= w_sp;
            IntDivOpM    <= IDivStartE & ~FDivStartE;
        end
    end

    fdivsqrt_stepctr #(
        .W(DURLEN)
    ) u_stepctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_en      (r_state == BUSY),
        .i_loadVal (CyclesE),
        .o_last    (w_stepLast)
    );

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Self-checking bench: directed table, corner sequences and random traffic vs a timeline model.
module tb_fdivsqrt_seq_ctrl;
    import fdivsqrt_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  FDivStartE, IDivStartE, SpecialCaseE, ISpecialCaseE;
    logic [CFG_DURLEN-1:0] CyclesE;
    logic                  StallM, FlushE;
    logic                  IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, SpecialCaseM, IntDivOpM;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic                  f, i, sp, isp;
        logic [CFG_DURLEN-1:0] cyc;
        logic                  stall, flush;
        logic                  eStart, eIter, eBusy, eDone, eSpM, eIntM;
    } vec_t;

    vec_t vecs[$];

    // Timeline model: an accepted op is described by the cycle its iterations end and the cycle done begins.
    bit mActive;
    int mCyc, mIterUntil, mDoneAt;
    bit mSpM, mIntM;

    fdivsqrt_seq_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .FDivStartE    (FDivStartE),
        .IDivStartE    (IDivStartE),
        .SpecialCaseE  (SpecialCaseE),
        .ISpecialCaseE (ISpecialCaseE),
        .CyclesE       (CyclesE),
        .StallM        (StallM),
        .FlushE        (FlushE),
        .IFDivStartE   (IFDivStartE),
        .IterEnE       (IterEnE),
        .FDivBusyE     (FDivBusyE),
        .FDivDoneE     (FDivDoneE),
        .SpecialCaseM  (SpecialCaseM),
        .IntDivOpM     (IntDivOpM)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(FDivStartE && IDivStartE)) else $error("[TB] both start requests raised together");
    end

    task automatic checkBit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic i, input logic sp, input logic isp,
                                 input logic [CFG_DURLEN-1:0] cyc, input logic stall, input logic flush);
        @(negedge clk);
        FDivStartE    = f;
        IDivStartE    = i;
        SpecialCaseE  = sp;
        ISpecialCaseE = isp;
        CyclesE       = cyc;
        StallM        = stall;
        FlushE        = flush;
        #1;
    endtask

    function automatic bit modelInIter();
        return mActive && (mCyc <= mIterUntil) && !FlushE;
    endfunction

    function automatic bit modelInDone();
        return mActive && (mCyc >= mDoneAt);
    endfunction

    function automatic bit modelStart();
        return (FDivStartE || IDivStartE) && !mActive && !FlushE;
    endfunction

    task automatic checkOutput(input string tag);
        bit inDone, st;
        inDone = modelInDone();
        st     = modelStart();
        checkBit({tag, ".IFDivStartE"}, IFDivStartE, st);
        checkBit({tag, ".IterEnE"},     IterEnE,     modelInIter());
        checkBit({tag, ".FDivDoneE"},   FDivDoneE,   inDone && !FlushE);
        checkBit({tag, ".FDivBusyE"},   FDivBusyE,   (mActive && !inDone) || (inDone && StallM) || st);
        checkBit({tag, ".SpecialCaseM"}, SpecialCaseM, mSpM);
        checkBit({tag, ".IntDivOpM"},   IntDivOpM,   mIntM);
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, ".IFDivStartE"}, IFDivStartE, 1'b0);
        checkBit({tag, ".IterEnE"},     IterEnE,     1'b0);
        checkBit({tag, ".FDivDoneE"},   FDivDoneE,   1'b0);
        checkBit({tag, ".FDivBusyE"},   FDivBusyE,   1'b0);
        checkBit({tag, ".SpecialCaseM"}, SpecialCaseM, 1'b0);
        checkBit({tag, ".IntDivOpM"},   IntDivOpM,   1'b0);
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic stepModel();
        bit inDone, st;
        @(posedge clk);
        inDone = modelInDone();
        st     = modelStart();
        if (mActive && (FlushE || (inDone && !StallM))) begin
            mActive = 0;
        end else if (st) begin
            mActive = 1;
            mSpM    = FDivStartE ? SpecialCaseE : ISpecialCaseE;
            mIntM   = IDivStartE && !FDivStartE;
            if (mSpM || CyclesE == 0) begin
                mIterUntil = mCyc;
                mDoneAt    = mCyc + 1;
            end else begin
                mIterUntil = mCyc + int'(CyclesE);
                mDoneAt    = mCyc + int'(CyclesE) + 1;
            end
        end
        mCyc++;
    endtask

    task automatic modelReset();
        mActive = 0;
        mSpM    = 0;
        mIntM   = 0;
    endtask

    task automatic addVec(input logic f, input logic i, input logic isp, input logic [CFG_DURLEN-1:0] cyc,
                          input logic eStart, input logic eIter, input logic eBusy, input logic eDone,
                          input logic eSpM, input logic eIntM);
        vec_t v;
        v.f = f; v.i = i; v.sp = 1'b0; v.isp = isp; v.cyc = cyc; v.stall = 1'b0; v.flush = 1'b0;
        v.eStart = eStart; v.eIter = eIter; v.eBusy = eBusy; v.eDone = eDone; v.eSpM = eSpM; v.eIntM = eIntM;
        vecs.push_back(v);
    endtask

    initial begin
        int doneCnt, busyCnt, startIdx0, startIdx1;

        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, 0, 0);
        checkAllZero("reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        mCyc = 0;

        // FP div with 5 iterations, then an integer special case.
        addVec(1, 0, 0, 6'd5, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) addVec(0, 0, 0, 6'd0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 0, 6'd0, 0, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 6'd7, 1, 0, 1, 0, 0, 0);
        addVec(0, 0, 0, 6'd0, 0, 0, 0, 1, 1, 1);
        addVec(0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < vecs.size(); k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            applyStimulus(vecs[k].f, vecs[k].i, vecs[k].sp, vecs[k].isp, vecs[k].cyc, vecs[k].stall, vecs[k].flush);
            checkBit({nm, ".IFDivStartE"}, IFDivStartE, vecs[k].eStart);
            checkBit({nm, ".IterEnE"},     IterEnE,     vecs[k].eIter);
            checkBit({nm, ".FDivBusyE"},   FDivBusyE,   vecs[k].eBusy);
            checkBit({nm, ".FDivDoneE"},   FDivDoneE,   vecs[k].eDone);
            checkBit({nm, ".SpecialCaseM"}, SpecialCaseM, vecs[k].eSpM);
            checkBit({nm, ".IntDivOpM"},   IntDivOpM,   vecs[k].eIntM);
            stepModel();
        end

        // Done held under a 4-cycle stall.
        doneCnt = 0;
        busyCnt = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k == 0, 0, 0, 0, 6'd3, (k >= 4 && k <= 7), 0);
            checkOutput("stall");
            doneCnt += FDivDoneE;
            if (k <= 7) busyCnt += FDivBusyE;
            stepModel();
        end
        checkBit("stall.doneCycles5", doneCnt == 5, 1'b1);
        checkBit("stall.busyThroughout", busyCnt == 8, 1'b1);

        // Flush on the second BUSY cycle of an 8-cycle op.
        doneCnt = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(k == 0, 0, 0, 0, 6'd8, 0, k == 2);
            checkOutput("flush");
            if (k == 2) checkBit("flush.iterMasked", IterEnE, 1'b0);
            if (k == 3) checkBit("flush.idleAfter", FDivBusyE, 1'b0);
            doneCnt += FDivDoneE;
            stepModel();
        end
        checkBit("flush.noDone", doneCnt == 0, 1'b1);

        // Asynchronous reset between edges in the middle of an op.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(k == 0, 0, 0, 0, 6'd10, 0, 0);
            checkOutput("arst");
            stepModel();
        end
        applyStimulus(0, 0, 0, 0, '0, 0, 0);
        checkBit("arst.iterBefore", IterEnE, 1'b1);
        #2 reset_n = 1'b0;
        #1 checkAllZero("arst.during");
        @(posedge clk);
        #1 checkAllZero("arst.held");
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, '0, 0, 0);
            checkOutput("arst.after");
            stepModel();
        end

        // FDivStartE held high: relaunch only once DONE returns to IDLE.
        startIdx0 = -1;
        startIdx1 = -1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 0, 0, 0, 6'd2, 0, 0);
            checkOutput("held");
            if (IFDivStartE) begin
                if (startIdx0 < 0) startIdx0 = k;
                else if (startIdx1 < 0) startIdx1 = k;
            end
            stepModel();
        end
        checkBit("held.firstStart", startIdx0 == 0, 1'b1);
        checkBit("held.secondStart", startIdx1 == 4, 1'b1);
        applyStimulus(0, 0, 0, 0, '0, 0, 0);
        checkOutput("held.drain");
        stepModel();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0, '0, 0, 0);
            stepModel();
        end
        checkOutput("drained");

        // Random traffic against the timeline model.
        for (int k = 0; k < 2000; k++) begin
            logic rf, ri;
            int sel;
            sel = $urandom_range(0, 9);
            rf  = (sel < 3);
            ri  = (sel >= 3 && sel < 5);
            applyStimulus(rf, ri, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                          CFG_DURLEN'($urandom_range(0, 10)), ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 31) == 0));
            checkOutput("rand");
            stepModel();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
